// File: rtl/ula_sequenciador.sv
// ula_sequenciador: control unit that sequences register-to-register
// instructions through an external combinational ALU (ULA).
// Accepts an instruction, presents operands and the control code to the
// ALU, writes the result back to an 8-entry register bank and updates the
// architectural Z/C/S/O flags according to the instruction class.
// Optional build macro: ULA_SEQ_ILLEGAL_TRAP_EN (pulses erro on unlisted codes).
module ula_sequenciador #(
  parameter int bits_palavra = 16,
  parameter int NUM_REGS     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [13:0]             instrucao,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic                    carga_valid,
  input  logic [2:0]              carga_reg,
  input  logic [bits_palavra-1:0] carga_dado,
  output logic [4:0]              ula_controle,
  output logic [bits_palavra-1:0] ula_operandoA,
  output logic [bits_palavra-1:0] ula_operandoB,
  input  logic [bits_palavra-1:0] ula_resultado,
  input  logic                    ula_Z,
  input  logic                    ula_C,
  input  logic                    ula_S,
  input  logic                    ula_O,
  output logic                    flag_Z,
  output logic                    flag_C,
  output logic                    flag_S,
  output logic                    flag_O,
  output logic                    concluido,
  output logic                    erro,
  input  logic [2:0]              leitura_reg,
  output logic [bits_palavra-1:0] leitura_dado
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Neutral "move" code: the ALU is parked on it whenever it is not in use.
  localparam logic [4:0] CTRL_MOVE = 5'b10000;

  logic [1:0]              estado;
  logic [bits_palavra-1:0] regs [NUM_REGS];
  logic [2:0]              rd_r;

  logic cls_arit;
  logic cls_desl;
  logic cls_logica;
  logic cls_ilegal;

  // Classify the latched control code to decide write-back and which flags move.
  always_comb begin
    cls_arit   = 1'b0;
    cls_desl   = 1'b0;
    cls_logica = 1'b0;
    cls_ilegal = 1'b0;
    case (ula_controle) inside
      5'b00000, 5'b00001, 5'b00011,
      5'b00100, 5'b00101, 5'b00110:     cls_arit   = 1'b1;
      5'b01000, 5'b01001:               cls_desl   = 1'b1;
      5'b10001, 5'b10010,
      [5'b10100:5'b11110]:              cls_logica = 1'b1;
      5'b00010, 5'b00111,
      [5'b01010:5'b01111]:              cls_ilegal = 1'b1;
      default:                          ;
    endcase
  end

  // Handshake and status outputs derive directly from the current state.
  assign instr_ready  = (estado == IDLE) && !carga_valid;
  assign concluido    = (estado == DONE);
  assign leitura_dado = regs[leitura_reg];

  // Main sequencer: loads, operand capture, write-back and flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado        <= IDLE;
      ula_controle  <= CTRL_MOVE;
      ula_operandoA <= '0;
      ula_operandoB <= '0;
      rd_r          <= '0;
      flag_Z        <= 1'b0;
      flag_C        <= 1'b0;
      flag_S        <= 1'b0;
      flag_O        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (estado)
        IDLE: begin
          if (carga_valid) begin
            regs[carga_reg] <= carga_dado;
          end else if (instr_valid) begin
            ula_controle  <= instrucao[13:9];
            rd_r          <= instrucao[8:6];
            ula_operandoA <= regs[instrucao[5:3]];
            ula_operandoB <= regs[instrucao[2:0]];
            estado        <= EXEC;
          end
        end
        EXEC: begin
          if (!cls_ilegal) begin
            regs[rd_r] <= ula_resultado;
          end
          if (cls_arit || cls_desl || cls_logica) begin
            flag_Z <= ula_Z;
            flag_S <= ula_S;
          end
          if (cls_arit || cls_desl) begin
            flag_C <= ula_C;
          end
          if (cls_arit) begin
            flag_O <= ula_O;
          end
          ula_controle <= CTRL_MOVE;
          estado       <= DONE;
        end
        DONE: begin
          estado <= IDLE;
        end
        default: begin
          estado <= IDLE;
        end
      endcase
    end
  end

`ifdef ULA_SEQ_ILLEGAL_TRAP_EN
  logic erro_r;

  // Remember that the executing code was unlisted so erro can pulse in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      erro_r <= 1'b0;
    end else if (estado == EXEC) begin
      erro_r <= cls_ilegal;
    end else if (estado == DONE) begin
      erro_r <= 1'b0;
    end
  end

  assign erro = (estado == DONE) && erro_r;
`else
  assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_ula_sequenciador.sv
// Testbench for ula_sequenciador: directed scenarios followed by randomized
// instructions, checked against a behavioural model of the register bank
// and architectural flags. A small behavioural ALU drives the ALU inputs.
module tb_ula_sequenciador;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [13:0]   instrucao;
  logic          instr_valid;
  logic          instr_ready;
  logic          carga_valid;
  logic [2:0]    carga_reg;
  logic [W-1:0]  carga_dado;
  logic [4:0]    ula_controle;
  logic [W-1:0]  ula_operandoA;
  logic [W-1:0]  ula_operandoB;
  logic [W-1:0]  ula_resultado;
  logic          ula_Z, ula_C, ula_S, ula_O;
  logic          flag_Z, flag_C, flag_S, flag_O;
  logic          concluido;
  logic          erro;
  logic [2:0]    leitura_reg;
  logic [W-1:0]  leitura_dado;
  logic [19:0]   aluOut;

  logic [W-1:0]  mregs [8];
  logic          mZ, mC, mS, mO;
  int            total = 0;
  int            bad = 0;

  ula_sequenciador #(.bits_palavra(W), .NUM_REGS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instrucao(instrucao), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .carga_valid(carga_valid), .carga_reg(carga_reg), .carga_dado(carga_dado),
    .ula_controle(ula_controle), .ula_operandoA(ula_operandoA), .ula_operandoB(ula_operandoB),
    .ula_resultado(ula_resultado),
    .ula_Z(ula_Z), .ula_C(ula_C), .ula_S(ula_S), .ula_O(ula_O),
    .flag_Z(flag_Z), .flag_C(flag_C), .flag_S(flag_S), .flag_O(flag_O),
    .concluido(concluido), .erro(erro),
    .leitura_reg(leitura_reg), .leitura_dado(leitura_dado)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {O,S,C,Z,result}.
  function automatic logic [19:0] aluFn(input logic [4:0] code, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    logic [15:0] r;
    logic c, o;
    case (code)
      5'b00000: begin t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16]; o = (a[15] == b[15]) && (r[15] != a[15]); end
      5'b00001: begin t = {1'b0, a} - {1'b0, b}; r = t[15:0]; c = t[16]; o = (a[15] != b[15]) && (r[15] != a[15]); end
      5'b01000: begin r = {a[14:0], 1'b0}; c = a[15]; o = 1'b0; end
      5'b01001: begin r = {a[15], a[15:1]}; c = a[0]; o = 1'b0; end
      5'b10001: begin r = a & b; c = ^a; o = ~^b; end
      default:  begin r = a ^ {b[7:0], b[15:8]} ^ {11'd0, code}; c = a[3] ^ b[5]; o = a[0] | b[15]; end
    endcase
    return {o, r[15], c, (r == 16'h0000), r};
  endfunction

  always_comb aluOut = aluFn(ula_controle, ula_operandoA, ula_operandoB);
  assign ula_resultado = aluOut[15:0];
  assign ula_Z = aluOut[16];
  assign ula_C = aluOut[17];
  assign ula_S = aluOut[18];
  assign ula_O = aluOut[19];

  // Instruction class: 0 arithmetic, 1 shift, 2 logic, 3 move, 4 unlisted.
  function automatic int codeClass(input int c);
    if (c == 0 || c == 1 || (c >= 3 && c <= 6)) return 0;
    if (c == 8 || c == 9) return 1;
    if (c == 17 || c == 18 || (c >= 20 && c <= 30)) return 2;
    if (c == 16 || c == 19 || c == 31) return 3;
    return 4;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mZ = 0; mC = 0; mS = 0; mO = 0;
  endtask

  task automatic loadReg(input logic [2:0] r, input logic [15:0] v);
    carga_valid = 1'b1; carga_reg = r; carga_dado = v;
    #1;
    checkOutput("load_ready_low", instr_ready, 0);
    @(posedge clk); #1;
    carga_valid = 1'b0;
    mregs[r] = v;
    leitura_reg = r;
    #1;
    checkOutput("load_readback", leitura_dado, v);
  endtask

  task automatic applyStimulus(input logic [4:0] code, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    int n;
    int cls;
    logic [19:0] a;
    logic [15:0] opA, opB;
    n = 0;
    while (!instr_ready && n < 10) begin @(posedge clk); #1; n++; end
    checkOutput("ready_before_issue", instr_ready, 1);
    instrucao = {code, rd, ra, rb};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    opA = mregs[ra]; opB = mregs[rb];
    a = aluFn(code, opA, opB);
    cls = codeClass(int'(code));
    checkOutput("exec_ready_low", instr_ready, 0);
    checkOutput("exec_concluido", concluido, 0);
    checkOutput("exec_controle", ula_controle, code);
    checkOutput("exec_opA", ula_operandoA, opA);
    checkOutput("exec_opB", ula_operandoB, opB);
    if (cls != 4) mregs[rd] = a[15:0];
    if (cls <= 2) begin mZ = a[16]; mS = a[18]; end
    if (cls <= 1) mC = a[17];
    if (cls == 0) mO = a[19];
    @(posedge clk); #1;
    checkOutput("done_concluido", concluido, 1);
    checkOutput("done_ready_low", instr_ready, 0);
`ifdef ULA_SEQ_ILLEGAL_TRAP_EN
    checkOutput("done_erro", erro, (cls == 4));
`else
    checkOutput("done_erro", erro, 0);
`endif
    leitura_reg = rd;
    #1;
    checkOutput("done_result", leitura_dado, mregs[rd]);
    checkOutput("done_flags", {flag_Z, flag_C, flag_S, flag_O}, {mZ, mC, mS, mO});
    @(posedge clk); #1;
    checkOutput("idle_concluido", concluido, 0);
    checkOutput("idle_erro", erro, 0);
    checkOutput("idle_controle", ula_controle, 5'b10000);
    checkOutput("idle_ready", instr_ready, 1);
  endtask

  initial begin
    instrucao = '0; instr_valid = 0; carga_valid = 0; carga_reg = '0; carga_dado = '0; leitura_reg = '0;
    modelReset();

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_controle", ula_controle, 5'b10000);
    checkOutput("rst_concluido", concluido, 0);
    checkOutput("rst_flags", {flag_Z, flag_C, flag_S, flag_O}, 4'b0000);
    @(negedge clk); rst_n = 1'b1; #1;
    checkOutput("rst_ready", instr_ready, 1);

    // Reset asserted in the middle of EXEC aborts the instruction
    loadReg(3'd1, 16'h1234);
    loadReg(3'd2, 16'h0F0F);
    instrucao = {5'b00000, 3'd3, 3'd1, 3'd2};
    instr_valid = 1'b1;
    @(posedge clk); #2;
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("mid_rst_controle", ula_controle, 5'b10000);
    checkOutput("mid_rst_opA", ula_operandoA, 0);
    checkOutput("mid_rst_opB", ula_operandoB, 0);
    checkOutput("mid_rst_concluido", concluido, 0);
    checkOutput("mid_rst_flags", {flag_Z, flag_C, flag_S, flag_O}, 4'b0000);
    leitura_reg = 3'd1; #1;
    checkOutput("mid_rst_r1", leitura_dado, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      leitura_reg = 3'(i); #1;
      checkOutput("mid_rst_bank", leitura_dado, 0);
    end

    // Add with signed overflow
    loadReg(3'd1, 16'h7FFF);
    loadReg(3'd2, 16'h0001);
    applyStimulus(5'b00000, 3'd3, 3'd1, 3'd2);
    leitura_reg = 3'd3; #1;
    checkOutput("add_r3", leitura_dado, 16'h8000);
    checkOutput("add_flags_ZCSO", {flag_Z, flag_C, flag_S, flag_O}, 4'b0011);

    // Logic AND keeps C and O
    applyStimulus(5'b10001, 3'd4, 3'd1, 3'd1);
    leitura_reg = 3'd4; #1;
    checkOutput("and_r4", leitura_dado, 16'h7FFF);
    checkOutput("and_flags_ZCSO", {flag_Z, flag_C, flag_S, flag_O}, 4'b0001);

    // Shift left and arithmetic shift right
    loadReg(3'd5, 16'h8001);
    applyStimulus(5'b01000, 3'd6, 3'd5, 3'd0);
    leitura_reg = 3'd6; #1;
    checkOutput("shl_r6", leitura_dado, 16'h0002);
    checkOutput("shl_flags_ZCSO", {flag_Z, flag_C, flag_S, flag_O}, 4'b0101);
    applyStimulus(5'b01001, 3'd6, 3'd5, 3'd0);
    leitura_reg = 3'd6; #1;
    checkOutput("asr_r6", leitura_dado, 16'hC000);
    checkOutput("asr_flags_ZCSO", {flag_Z, flag_C, flag_S, flag_O}, 4'b0111);

    // Load and instruction presented together: load wins, instruction waits
    carga_valid = 1'b1; carga_reg = 3'd7; carga_dado = 16'hABCD;
    instrucao = {5'b00000, 3'd0, 3'd7, 3'd7}; instr_valid = 1'b1;
    #1;
    checkOutput("conc_ready_low", instr_ready, 0);
    @(posedge clk); #1;
    carga_valid = 1'b0;
    mregs[7] = 16'hABCD;
    checkOutput("conc_not_accepted", ula_controle, 5'b10000);
    applyStimulus(5'b00000, 3'd0, 3'd7, 3'd7);
    leitura_reg = 3'd0; #1;
    checkOutput("conc_r0", leitura_dado, 16'h579A);

    // Unlisted code: no write-back, no flag change
    applyStimulus(5'b00010, 3'd3, 3'd1, 3'd2);
    leitura_reg = 3'd3; #1;
    checkOutput("nop_r3", leitura_dado, 16'h8000);

    // Randomized loads and instructions
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 2) == 0) loadReg(3'($urandom_range(0, 7)), 16'($urandom));
      applyStimulus(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // Final sweep of the register bank
    for (int i = 0; i < 8; i++) begin
      leitura_reg = 3'(i); #1;
      checkOutput("final_bank", leitura_dado, mregs[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
